// File: rtl/fir_out_collector.sv
// Output sink for the FIR result stream: rescale, buffer in a FWFT FIFO, hand off over valid/ready.
// Define FIR_OUT_SAT_EN to saturate on narrowing; otherwise the narrowed sample wraps (truncation).
module fir_out_collector #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 8,
   parameter int SHIFT = 0,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IN_W-1:0]          fir_data,
   input  logic                     fir_valid,
   output logic [OUT_W-1:0]         m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fill,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [OUT_W-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [AW:0]      fill_reg, fill_next, remain;
   logic             m_valid_reg, m_valid_next;
   logic [OUT_W-1:0] m_data_reg, m_data_next;
   logic             overflow_reg, overflow_next;

   logic signed [IN_W-1:0] shifted;
   logic [OUT_W-1:0]       scaled;
   logic                   pop, push, drop, full;

   assign shifted = $signed(fir_data) >>> SHIFT;

`ifdef FIR_OUT_SAT_EN
   localparam logic signed [IN_W-1:0] S_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] S_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      scaled = OUT_W'(shifted);
      if (shifted > S_MAX)
         scaled = {1'b0, {(OUT_W-1){1'b1}}};
      else if (shifted < S_MIN)
         scaled = {1'b1, {(OUT_W-1){1'b0}}};
   end
`else
   assign scaled = OUT_W'(shifted);
`endif

   // A pop on the same edge frees the slot a push needs, so a full FIFO still accepts.
   always_comb begin
      full = (fill_reg == FULL_CNT);
      pop  = m_valid_reg & m_ready;
      push = fir_valid & (~full | pop);
      drop = fir_valid & full & ~pop;

      wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      remain      = pop  ? fill_reg - 1'b1   : fill_reg;

      fill_next = fill_reg;
      case ({push, pop})
         2'b10:   fill_next = fill_reg + 1'b1;
         2'b01:   fill_next = fill_reg - 1'b1;
         default: fill_next = fill_reg;
      endcase

      m_valid_next = (fill_next != '0);

      // Next head is the incoming sample when nothing older survives this edge.
      if (fill_next == '0)
         m_data_next = '0;
      else if (remain == '0)
         m_data_next = scaled;
      else
         m_data_next = mem[rd_ptr_next];

      if (drop)
         overflow_next = 1'b1;
      else if (clr_ovf)
         overflow_next = 1'b0;
      else
         overflow_next = overflow_reg;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= scaled;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fill_reg     <= '0;
         m_valid_reg  <= 1'b0;
         m_data_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         fill_reg     <= fill_next;
         m_valid_reg  <= m_valid_next;
         m_data_reg   <= m_data_next;
         overflow_reg <= overflow_next;
      end
   end

   assign m_data   = m_data_reg;
   assign m_valid  = m_valid_reg;
   assign fill     = fill_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_fir_out_collector.sv
// Bench for fir_out_collector: queue-based reference model checked every cycle plus literal pins.
// Expectations follow FIR_OUT_SAT_EN the same way the design does.
module tb_fir_out_collector;
   localparam int IN_W  = 16;
   localparam int OUT_W = 8;
   localparam int DEPTH = 8;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1;
   logic [IN_W-1:0] fir_data = '0;
   logic            fir_valid = 1'b0;
   logic            m_ready = 1'b0;
   logic            clr_ovf = 1'b0;

   logic [OUT_W-1:0] m_data, m_data2;
   logic             m_valid, m_valid2;
   logic [FW-1:0]    fill, fill2;
   logic             overflow, overflow2;

   fir_out_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .fir_data(fir_data), .fir_valid(fir_valid),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .fill(fill), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   fir_out_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(2), .DEPTH(DEPTH)) dut_sh2 (
      .clk(clk), .rst(rst), .fir_data(fir_data), .fir_valid(fir_valid),
      .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
      .fill(fill2), .overflow(overflow2), .clr_ovf(clr_ovf)
   );

   int checks = 0;
   int passed = 0;
   bit started = 1'b0;
   int q[$];
   bit ovf_m = 1'b0;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   function automatic int model_scale(int x, int sh);
      int v;
      int lim;
      v   = x >>> sh;
      lim = 1 << (OUT_W - 1);
`ifdef FIR_OUT_SAT_EN
      if (v > lim - 1) v = lim - 1;
      else if (v < -lim) v = -lim;
`else
      v = v & ((lim << 1) - 1);
      if (v >= lim) v = v - 2 * lim;
`endif
      return v;
   endfunction

   // Reference model: plain queue with the push/pop/drop rules.
   always @(posedge clk) begin
      bit pop_m;
      bit full_m;
      if (rst && started) begin
         pop_m  = (q.size() > 0) && m_ready;
         full_m = (q.size() == DEPTH);
         if (pop_m) void'(q.pop_front());
         if (fir_valid && (!full_m || pop_m))
            q.push_back(model_scale(int'($signed(fir_data)), 0));
         if (fir_valid && full_m && !pop_m) ovf_m = 1'b1;
         else if (clr_ovf) ovf_m = 1'b0;
      end
   end

   always @(negedge rst) begin
      q.delete();
      ovf_m = 1'b0;
   end

   always @(negedge clk) begin
      if (started) begin
         check("cyc_m_valid", int'(m_valid), int'(q.size() != 0));
         check("cyc_fill", int'(fill), q.size());
         check("cyc_m_data", int'($signed(m_data)), (q.size() != 0) ? q[0] : 0);
         check("cyc_overflow", int'(overflow), int'(ovf_m));
      end
   end

   task automatic cyc(bit v, int d, bit r, bit c);
      fir_valid = v;
      fir_data  = IN_W'(d);
      m_ready   = r;
      clr_ovf   = c;
      @(posedge clk);
      #1;
   endtask

   int exp_basic[3] = '{45, -27, 10};
   int exp_pos, exp_neg;

   initial begin
`ifdef FIR_OUT_SAT_EN
      exp_pos = 127;
      exp_neg = -128;
`else
      exp_pos = 44;
      exp_neg = -44;
`endif
      #2 rst = 1'b0;
      started = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fill", int'(fill), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_overflow", int'(overflow), 0);
      rst = 1'b1;
      repeat (5) cyc(0, 0, 0, 0);
      check("idle_fill", int'(fill), 0);
      check("idle_m_valid", int'(m_valid), 0);

      // Basic ordering
      cyc(1, 45, 0, 0);
      cyc(1, -27, 0, 0);
      cyc(1, 10, 0, 0);
      check("basic_fill", int'(fill), 3);
      check("basic_head", int'($signed(m_data)), 45);
      for (int i = 0; i < 3; i++) begin
         check("basic_pop", int'($signed(m_data)), exp_basic[i]);
         cyc(0, 0, 1, 0);
      end
      check("basic_empty_fill", int'(fill), 0);
      check("basic_empty_data", int'(m_data), 0);

      // Overflow
      for (int i = 1; i <= 9; i++) cyc(1, i, 0, 0);
      check("ovf_fill", int'(fill), 8);
      check("ovf_flag", int'(overflow), 1);
      for (int i = 1; i <= 8; i++) begin
         check("ovf_pop", int'($signed(m_data)), i);
         cyc(0, 0, 1, 0);
      end
      check("ovf_drained", int'(fill), 0);
      check("ovf_sticky", int'(overflow), 1);
      cyc(0, 0, 0, 1);
      check("ovf_cleared", int'(overflow), 0);

      // Full with simultaneous push and pop
      for (int i = 11; i <= 18; i++) cyc(1, i, 0, 0);
      check("full_fill", int'(fill), 8);
      cyc(1, 100, 1, 0);
      check("fullpp_fill", int'(fill), 8);
      check("fullpp_ovf", int'(overflow), 0);
      for (int i = 12; i <= 18; i++) begin
         check("fullpp_pop", int'($signed(m_data)), i);
         cyc(0, 0, 1, 0);
      end
      check("fullpp_last", int'($signed(m_data)), 100);
      cyc(0, 0, 1, 0);
      check("fullpp_empty", int'(fill), 0);

      // Narrowing
      cyc(1, 300, 0, 0);
      check("narrow_pos", int'($signed(m_data)), exp_pos);
      check("narrow_pos_sh2", int'($signed(m_data2)), 75);
      cyc(0, 0, 1, 0);
      cyc(1, -300, 0, 0);
      check("narrow_neg", int'($signed(m_data)), exp_neg);
      check("narrow_neg_sh2", int'($signed(m_data2)), -75);
      cyc(0, 0, 1, 0);
      cyc(1, -20, 0, 0);
      check("narrow_m20", int'($signed(m_data)), -20);
      check("narrow_m20_sh2", int'($signed(m_data2)), -5);
      cyc(0, 0, 1, 0);

      // Interleaved traffic wrapping the pointers
      for (int i = 0; i < 20; i++) cyc(1, i * 13 - 100, (i % 4) != 0, 0);
      repeat (10) cyc(0, 0, 1, 0);
      check("wrap_drained", int'(fill), 0);

      // Asynchronous reset with data buffered
      for (int i = 0; i < 5; i++) cyc(1, 50 + i, 0, 0);
      check("prerst_fill", int'(fill), 5);
      rst = 1'b0;
      #1;
      check("async_fill", int'(fill), 0);
      check("async_m_valid", int'(m_valid), 0);
      check("async_m_data", int'(m_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) cyc(0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
